sd_seq_check: RTL and testbench
===============================

SD_SEQ_CHECK -- requirements
Module: sd_seq_check

Interface
REQ-001 SHALL have parameter width, default 8, total data width.
REQ-002 SHALL have parameter tag_sz, default 1, tag field width in data MSBs; count_sz = width-tag_sz.
REQ-003 SHALL have parameter tag_val, default 0, expected tag value.
REQ-004 SHALL have parameter pat_dep, default 8, drdy pattern depth, 1..32.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port c_srdy  input  1  upstream source ready.
REQ-008 SHALL have port c_drdy  output  1  checker ready to accept.
REQ-009 SHALL have port c_data  input  width  upstream data, {tag, count}.
REQ-010 SHALL have port start  input  1  one-cycle pulse launching a run.
REQ-011 SHALL have port amount  input  32  words to accept in the run, sampled on start.
REQ-012 SHALL have port pat  input  pat_dep  drdy pattern, sampled on start.
REQ-013 SHALL have port done  output  1  run complete.
REQ-014 SHALL have port err  output  1  sticky mismatch flag.
REQ-015 SHALL have port err_cnt  output  16  mismatch count.
REQ-016 SHALL have port rx_cnt  output  16  accepted-word count.

Function
REQ-017 SHALL use three states: IDLE, RUN, DONE.
REQ-018 In IDLE and DONE, c_drdy SHALL be 0.
REQ-019 start in IDLE or DONE SHALL load remaining=amount, latch pat, set ptr=0, clear done; next state RUN, or DONE if amount==0.
REQ-020 start while in RUN SHALL be ignored.
REQ-021 In RUN, c_drdy SHALL equal latched pat[ptr], registered; ptr SHALL advance every RUN cycle and wrap from pat_dep-1 to 0.
REQ-022 A transfer SHALL occur only on a cycle with c_srdy=1 and c_drdy=1; c_data SHALL be ignored otherwise.
REQ-023 On each transfer, rx_cnt SHALL increment, saturating at 16'hFFFF.
REQ-024 On each transfer, remaining SHALL decrement; the transfer that makes remaining 0 SHALL move the FSM to DONE next cycle, with c_drdy 0 from that cycle.
REQ-025 A transfer SHALL match when c_data[width-1:count_sz]==tag_val and c_data[count_sz-1:0]==exp.
REQ-026 On a match, exp SHALL become exp+1 modulo 2^count_sz, so all-ones wraps to 0 without error.
REQ-027 On a mismatch, err SHALL set, err_cnt SHALL increment saturating at 16'hFFFF, and exp SHALL resync to received count+1 modulo 2^count_sz; a single dropped word SHALL produce exactly one error.
REQ-028 exp, err, err_cnt and rx_cnt SHALL persist across runs and be cleared only by reset.
REQ-029 done SHALL be 1 exactly while in DONE.
REQ-030 All outputs SHALL be registered; no combinational path SHALL exist from c_srdy to c_drdy.
REQ-031 An all-zero pat SHALL keep c_drdy 0 and the FSM in RUN indefinitely; this is legal, not an error.

Reset
REQ-032 reset SHALL force IDLE, c_drdy=0, done=0, err=0, err_cnt=0, rx_cnt=0, exp=0, ptr=0, remaining=0.
REQ-033 reset asserted mid-run SHALL abort the run with the REQ-032 values on the next cycle, with no transfer counted on the reset cycle.
REQ-034 reset SHALL take priority over start.

Verification
REQ-035 Reset, then start with amount=10 and pat=8'hFF against an always-ready incrementing source -> 10 transfers, data 0..9, rx_cnt=10, err_cnt=0, done=1, c_drdy=0 after the 10th transfer.
REQ-036 pat=8'b0000_0101, amount=4 -> c_drdy high only on RUN cycles ptr=0 and ptr=2 of each 8-cycle period; 4 clean transfers; done=1.
REQ-037 Source skips value 3 (sends 0,1,2,4,5), amount=5 -> err=1, err_cnt=1, exp=6 at DONE.
REQ-038 width=8, tag_sz=1, exp preset near 7'h7F via prior runs, stream 7E,7F,00 -> no error across the wrap; a tag bit of 1 with tag_val=0 -> err_cnt increments.
REQ-039 Reset asserted after 3 of 8 words -> next cycle IDLE, counters 0; a fresh start with amount=2 then expects data 0,1.
REQ-040 start with amount=0 -> DONE next cycle, no c_drdy assertion, rx_cnt unchanged.

Source files
------------

// File: rtl/sd_seq_check.sv
`default_nettype none
// ============================================================================
// Module      : sd_seq_check
// Description : Sequence checker sink. Accepts a programmed number of words
//               under a repeating drdy pattern and checks that each word
//               carries the expected tag and an incrementing count.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_seq_check #(
    parameter int width   = 8,
    parameter int tag_sz  = 1,
    parameter int tag_val = 0,
    parameter int pat_dep = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c_srdy,
    output logic               c_drdy,
    input  logic [width-1:0]   c_data,
    input  logic               start,
    input  logic [31:0]        amount,
    input  logic [pat_dep-1:0] pat,
    output logic               done,
    output logic               err,
    output logic [15:0]        err_cnt,
    output logic [15:0]        rx_cnt
);

    localparam int C_COUNT_SZ = width - tag_sz;
    localparam int C_PTR_W    = (pat_dep > 1) ? $clog2(pat_dep) : 1;
    localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(pat_dep - 1);
    localparam logic [tag_sz-1:0]  C_TAG      = tag_sz'(tag_val);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state, w_state_n;
    logic [C_PTR_W-1:0]    r_ptr, w_ptr_n, w_ptr_inc;
    logic [31:0]           r_rem, w_rem_n;
    logic [pat_dep-1:0]    r_pat, w_pat_n;
    logic                  r_drdy, w_drdy_n;
    logic                  r_done, w_done_n;
    logic [C_COUNT_SZ-1:0] r_exp, w_exp_n;
    logic                  r_err, w_err_n;
    logic [15:0]           r_err_cnt, w_err_cnt_n;
    logic [15:0]           r_rx_cnt, w_rx_cnt_n;

    logic                  w_xfer;
    logic                  w_match;
    logic [tag_sz-1:0]     w_rx_tag;
    logic [C_COUNT_SZ-1:0] w_rx_count;

    assign w_rx_tag   = c_data[width-1:C_COUNT_SZ];
    assign w_rx_count = c_data[C_COUNT_SZ-1:0];
    assign w_match    = (w_rx_tag == C_TAG) && (w_rx_count == r_exp);
    // A word is only taken while running and both sides are ready.
    assign w_xfer     = (r_state == S_RUN) && c_srdy && r_drdy;
    assign w_ptr_inc  = (r_ptr == C_PTR_LAST) ? '0 : r_ptr + 1'b1;

    assign c_drdy  = r_drdy;
    assign done    = r_done;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;
    assign rx_cnt  = r_rx_cnt;

    // Next-state and next-output computation; drdy is looked ahead one
    // cycle so the output is a plain flop with no path from c_srdy.
    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_rem_n     = r_rem;
        w_pat_n     = r_pat;
        w_drdy_n    = r_drdy;
        w_done_n    = r_done;
        w_exp_n     = r_exp;
        w_err_n     = r_err;
        w_err_cnt_n = r_err_cnt;
        w_rx_cnt_n  = r_rx_cnt;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_drdy_n = 1'b0;
                if (start) begin
                    w_rem_n = amount;
                    w_pat_n = pat;
                    w_ptr_n = '0;
                    if (amount == 32'd0) begin
                        w_state_n = S_DONE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = S_RUN;
                        w_done_n  = 1'b0;
                        w_drdy_n  = pat[0];
                    end
                end
            end
            S_RUN: begin
                w_ptr_n  = w_ptr_inc;
                w_drdy_n = r_pat[w_ptr_inc];
                if (w_xfer) begin
                    w_rem_n = r_rem - 32'd1;
                    // Last word of the run: close the window immediately.
                    if (r_rem == 32'd1) begin
                        w_state_n = S_DONE;
                        w_done_n  = 1'b1;
                        w_drdy_n  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_drdy_n  = 1'b0;
                w_done_n  = 1'b0;
            end
        endcase

        // Sequence check; a mismatch resyncs to the received count so one
        // dropped word costs exactly one error.
        if (w_xfer) begin
            if (r_rx_cnt != 16'hFFFF) begin
                w_rx_cnt_n = r_rx_cnt + 16'd1;
            end
            if (w_match) begin
                w_exp_n = r_exp + 1'b1;
            end else begin
                w_exp_n = w_rx_count + 1'b1;
                w_err_n = 1'b1;
                if (r_err_cnt != 16'hFFFF) begin
                    w_err_cnt_n = r_err_cnt + 16'd1;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_rem     <= '0;
            r_pat     <= '0;
            r_drdy    <= 1'b0;
            r_done    <= 1'b0;
            r_exp     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_rx_cnt  <= '0;
        end else begin
            r_state   <= w_state_n;
            r_ptr     <= w_ptr_n;
            r_rem     <= w_rem_n;
            r_pat     <= w_pat_n;
            r_drdy    <= w_drdy_n;
            r_done    <= w_done_n;
            r_exp     <= w_exp_n;
            r_err     <= w_err_n;
            r_err_cnt <= w_err_cnt_n;
            r_rx_cnt  <= w_rx_cnt_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_seq_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_seq_check
// Description : Self-checking bench for sd_seq_check (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_seq_check;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_srdy = 1'b0;
    logic        c_drdy;
    logic [7:0]  c_data = '0;
    logic        start = 1'b0;
    logic [31:0] amount = '0;
    logic [7:0]  pat = '0;
    logic        done;
    logic        err;
    logic [15:0] err_cnt;
    logic [15:0] rx_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sd_seq_check #(.width(8), .tag_sz(1), .tag_val(0), .pat_dep(8)) dut (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy),
        .c_data(c_data), .start(start), .amount(amount), .pat(pat),
        .done(done), .err(err), .err_cnt(err_cnt), .rx_cnt(rx_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a run is "cycle k of the run", drdy = pat[k mod 8].
    bit          m_run, m_done, m_err, m_drdy;
    logic [15:0] m_errc, m_rxc;
    logic [6:0]  m_exp;
    logic [7:0]  m_pat;
    int          m_k;
    longint      m_rem;

    task automatic model(input bit rs, input bit sr, input logic [7:0] d,
                         input bit st, input logic [31:0] am, input logic [7:0] p);
        bit tx;
        if (rs) begin
            m_run = 0; m_done = 0; m_err = 0; m_drdy = 0;
            m_errc = 0; m_rxc = 0; m_exp = 0; m_k = 0; m_rem = 0; m_pat = 0;
            return;
        end
        tx = m_run && sr && m_drdy;
        if (tx) begin
            if (m_rxc < 16'hFFFF) m_rxc = m_rxc + 1;
            if (d[7] == 1'b0 && d[6:0] == m_exp) begin
                m_exp = 7'((int'(m_exp) + 1) % 128);
            end else begin
                m_err = 1;
                if (m_errc < 16'hFFFF) m_errc = m_errc + 1;
                m_exp = 7'((int'(d[6:0]) + 1) % 128);
            end
            m_rem = m_rem - 1;
        end
        if (m_run) begin
            if (tx && m_rem == 0) begin
                m_run = 0; m_done = 1; m_drdy = 0;
            end else begin
                m_k = m_k + 1;
                m_drdy = m_pat[m_k % 8];
            end
        end else if (st) begin
            m_rem = longint'(am); m_pat = p; m_k = 0;
            if (am == 0) begin
                m_done = 1; m_drdy = 0;
            end else begin
                m_run = 1; m_done = 0; m_drdy = p[0];
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".c_drdy"}, 16'(c_drdy), 16'(m_drdy));
        chk({tag, ".done"},   16'(done),   16'(m_done));
        chk({tag, ".err"},    16'(err),    16'(m_err));
        chk({tag, ".err_cnt"}, err_cnt, m_errc);
        chk({tag, ".rx_cnt"},  rx_cnt,  m_rxc);
    endtask

    task automatic step(input bit rs, input bit sr, input logic [7:0] d,
                        input bit st, input logic [31:0] am, input logic [7:0] p);
        reset = rs; c_srdy = sr; c_data = d; start = st; amount = am; pat = p;
        @(posedge clk);
        model(rs, sr, d, st, am, p);
        #1;
    endtask

    logic [7:0] src [0:15];

    // Start a run and feed src[0..n-1] whenever the checker is ready.
    task automatic stream(input string tag, input int amt, input logic [7:0] p, input int n);
        int idx;
        bit sr, tx;
        logic [7:0] d;
        idx = 0;
        step(0, 0, 8'h00, 1, amt, p);
        check_model({tag, ".start"});
        for (int c = 0; c < 200 && m_run; c++) begin
            sr = (idx < n);
            d  = sr ? src[idx] : 8'h00;
            tx = m_drdy && sr;
            step(0, sr, d, 0, 0, p);
            check_model(tag);
            if (tx) idx++;
        end
        if (m_run) begin
            n_tests++; n_fail++;
            $display("FAIL %s.timeout: run still active, expected done", tag);
        end
    endtask

    typedef struct {
        bit rs; bit sr; logic [7:0] d; bit st; logic [31:0] am; logic [7:0] p;
        bit e_drdy; bit e_done; bit e_err; logic [15:0] e_errc; logic [15:0] e_rxc;
    } vec_t;
    vec_t tv [14];

    initial begin
        // Hand-derived vectors: amount=0, then amount=2 under pat 0000_0101
        // with a start pulse mid-run that must be ignored.
        tv[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 0};
        tv[2]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0};
        tv[3]  = '{0, 0, 8'h00, 1, 2, 8'h05, 1, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0};
        tv[6]  = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tv[7]  = '{0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tv[8]  = '{0, 1, 8'h55, 1, 9, 8'hFF, 0, 0, 0, 0, 1};
        tv[9]  = '{0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tv[10] = '{0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tv[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1};
        tv[12] = '{0, 1, 8'h01, 0, 0, 8'h00, 0, 1, 0, 0, 2};
        tv[13] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 2};

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(tv[i].rs, tv[i].sr, tv[i].d, tv[i].st, tv[i].am, tv[i].p);
            chk($sformatf("vec%0d.c_drdy", i), 16'(c_drdy), 16'(tv[i].e_drdy));
            chk($sformatf("vec%0d.done", i),   16'(done),   16'(tv[i].e_done));
            chk($sformatf("vec%0d.err", i),    16'(err),    16'(tv[i].e_err));
            chk($sformatf("vec%0d.err_cnt", i), err_cnt, tv[i].e_errc);
            chk($sformatf("vec%0d.rx_cnt", i),  rx_cnt,  tv[i].e_rxc);
        end

        // Ten clean words under an always-ready pattern.
        step(1, 0, 0, 0, 0, 0);
        check_model("reset");
        for (int i = 0; i < 10; i++) src[i] = 8'(i);
        stream("run10", 10, 8'hFF, 10);
        chk("run10.rx_cnt", rx_cnt, 16'd10);
        chk("run10.err_cnt", err_cnt, 16'd0);
        chk("run10.done", 16'(done), 16'd1);
        chk("run10.c_drdy", 16'(c_drdy), 16'd0);

        // Sparse pattern, four clean words.
        for (int i = 0; i < 4; i++) src[i] = 8'(10 + i);
        stream("pat05", 4, 8'h05, 4);
        chk("pat05.err_cnt", err_cnt, 16'd0);
        chk("pat05.done", 16'(done), 16'd1);

        // Dropped word 3: one error, then expected value resyncs to 6.
        step(1, 0, 0, 0, 0, 0);
        src[0] = 0; src[1] = 1; src[2] = 2; src[3] = 4; src[4] = 5;
        stream("skip3", 5, 8'hFF, 5);
        chk("skip3.err", 16'(err), 16'd1);
        chk("skip3.err_cnt", err_cnt, 16'd1);
        src[0] = 8'h06;
        stream("resync6", 1, 8'hFF, 1);
        chk("resync6.err_cnt", err_cnt, 16'd1);

        // Count wrap 7E,7F,00 is clean; a set tag bit is an error.
        step(1, 0, 0, 0, 0, 0);
        src[0] = 8'h7D;
        stream("preset", 1, 8'hFF, 1);
        chk("preset.err_cnt", err_cnt, 16'd1);
        src[0] = 8'h7E; src[1] = 8'h7F; src[2] = 8'h00;
        stream("wrap", 3, 8'hFF, 3);
        chk("wrap.err_cnt", err_cnt, 16'd1);
        src[0] = 8'h81;
        stream("tagbit", 1, 8'hFF, 1);
        chk("tagbit.err_cnt", err_cnt, 16'd2);

        // Reset mid-run after three words aborts and clears everything.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'(i), 0, 0, 0);
            check_model("abort.pre");
        end
        chk("abort.rx3", rx_cnt, 16'd3);
        step(1, 1, 8'h03, 0, 0, 0);
        chk("abort.c_drdy", 16'(c_drdy), 16'd0);
        chk("abort.done", 16'(done), 16'd0);
        chk("abort.rx_cnt", rx_cnt, 16'd0);
        chk("abort.err_cnt", err_cnt, 16'd0);
        src[0] = 0; src[1] = 1;
        stream("fresh", 2, 8'hFF, 2);
        chk("fresh.rx_cnt", rx_cnt, 16'd2);
        chk("fresh.err_cnt", err_cnt, 16'd0);
        chk("fresh.done", 16'(done), 16'd1);

        // Randomized traffic against the model.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit rs, sr, st;
            logic [7:0] d, p;
            logic [31:0] am;
            rs = ($urandom_range(0, 249) == 0);
            st = m_run ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 5) == 0);
            am = 32'($urandom_range(0, 6));
            p  = 8'($urandom);
            sr = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {1'b0, m_exp};
            step(rs, sr, d, st, am, p);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
